mdu_hilo_ctrl: RTL and testbench
================================

Name: mdu_hilo_ctrl

Overview:
- Controller for the multiply/divide resource and the HI/LO register pair in the EXE stage; executes OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI and OP_MTLO.
- Holds the pipeline with a stall request while a multi-cycle operation runs.
- Writes HI/LO on completion and aborts cleanly on a pipeline flush.
- HI/LO values are exported for OP_MFHI/OP_MFLO selection in the EXE stage.

Parameters:
- MUL_LATENCY, 2: cycles spent in MUL state (registered product path); legal range 1..4.
- DIV_ZERO_FAST, 1: 1 = divide-by-zero skips iteration and goes straight to FIX.
- HILO_RST_VAL, 32'h0: reset value of HI and LO.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- EXE_MDUOp  in  3  MDUOpType: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- EXE_Valid  in  1  EXE holds a live instruction
- EXE_BusA  in  32  rs operand, already bypassed
- EXE_BusB  in  32  rt operand, already bypassed
- EXE_Advance  in  1  EXE instruction moves to MEM this cycle
- MDU_Flush  in  1  exception/ERET flush of EXE
- MDU_Stall  out  1  freeze IF/ID/EXE
- MDU_Busy  out  1  state != IDLE
- MDU_Done  out  1  one-cycle pulse on the HI/LO write edge
- HI_Out  out  32  current HI
- LO_Out  out  32  current LO

Behaviour:
- Reset (asynchronous): state=IDLE, HI=LO=HILO_RST_VAL, done_hold=0, counter=0. MDU_Stall, MDU_Busy and MDU_Done are all 0.
- States: IDLE, MUL, DIV, FIX.
- start = EXE_Valid & !MDU_Flush & state==IDLE & !done_hold & op in {MULT, MULTU, DIV, DIVU}.
- MDU_Stall = start | (state != IDLE), combinational. A flush drops it in the same cycle.
- IDLE + start(MULT/MULTU):
  - Latch operands; go to MUL, cnt=MUL_LATENCY-1.
  - MUL decrements cnt. At cnt==0: {HI,LO} <= 64-bit product (signed for MULT, unsigned for MULTU); go to IDLE.
  - Total stall cycles = 1 + MUL_LATENCY.
- IDLE + start(DIV/DIVU):
  - Latch |A| and |B| (raw operands for DIVU) and the signs; go to DIV, cnt=31.
  - Exception: if B==0 and DIV_ZERO_FAST, go to FIX with q=32'hFFFFFFFF, r=A.
  - DIV: one restoring iteration per cycle, 32 cycles; go to FIX when cnt==0.
  - FIX sign rules:
    - Quotient is negated if sign(A)!=sign(B).
    - Remainder takes sign(A).
    - Sign rules are skipped for DIVU and for the zero-divisor path.
  - FIX writes LO=q, HI=r; go to IDLE.
  - Stall cycles: 34 normal, 2 for a zero divisor.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- HI/LO write edge: sets done_hold=1 and pulses MDU_Done for that cycle.
- done_hold: cleared on EXE_Advance. This prevents the same instruction restarting while EXE is held for another reason.
- MTHI/MTLO: in IDLE with EXE_Valid & !MDU_Flush & !done_hold, write HI (or LO) <= EXE_BusA at the cycle end. No stall; sets done_hold.
- MDU_Flush:
  - In any state: go to IDLE next edge, no HI/LO write, done_hold cleared.
  - A flush in the MUL-final or FIX cycle suppresses the write and the MDU_Done pulse.
- HI_Out/LO_Out are the registers directly. No same-cycle bypass; the stall guarantees ordering for a following MFHI/MFLO.
- Mid-operation reset: immediate IDLE, HI/LO restored to HILO_RST_VAL.
- NONE, or any op while done_hold=1: no action.

Decomposition:
- Shared package (CPU_Defines): MDUOpType enum (3-bit) and MDUStateType enum (IDLE, MUL, DIV, FIX).
- Sub-module div_iter_core: 32-cycle unsigned restoring divider datapath (remainder/quotient shift registers and counter). mdu_hilo_ctrl owns the FSM, sign handling, multiplier and HI/LO.

Test Plan:
- MULTU A=0xFFFFFFFF, B=2 -> MDU_Stall high 3 cycles (MUL_LATENCY=2); HI=0x00000001, LO=0xFFFFFFFE; one MDU_Done pulse.
- DIV A=-7 (0xFFFFFFF9), B=2 -> 34 stall cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU on the same operands -> LO=0x7FFFFFFC, HI=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU A=5, B=0 -> 2 stall cycles, LO=0xFFFFFFFF, HI=5.
- Start DIV, assert MDU_Flush at iteration 10 -> stall drops that cycle; HI/LO unchanged; no MDU_Done; next MULT starts normally.
- MULT completes with EXE_Advance held low 3 more cycles -> no restart, single write. MTLO 0x1234 after advance -> LO=0x1234 next edge, zero stall.
- Assert rst mid-DIV -> all outputs 0 and HI=LO=HILO_RST_VAL immediately (asynchronous, not at the next edge).

Source files
------------

// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared multiply/divide types: EXE-stage MDU op codes, controller states
// and the signed-magnitude helper used when loading the divider.
package mdu_hilo_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } mdu_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } mdu_state_t;

   // Magnitude of a two's-complement value when en is set, raw value otherwise.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
      return (en && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_div.sv
// Unsigned restoring divider datapath: one quotient bit per step, 32 steps.
// Latency: 32 step cycles after load; no backpressure, the controller gates step.
// Results stay stable in quotient/remainder once stepping stops.
module div_iter_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        last
);

   logic [31:0] dvsr;
   logic [4:0]  cnt;
   logic [32:0] shifted;
   logic [32:0] diff;

   // Partial remainder is always below the divisor, so bit 32 of diff is a clean borrow.
   always_comb begin
      shifted = {remainder, quotient[31]};
      diff    = shifted - {1'b0, dvsr};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remainder <= '0;
         quotient  <= '0;
         dvsr      <= '0;
         cnt       <= '0;
      end else if (load) begin
         remainder <= '0;
         quotient  <= dividend;
         dvsr      <= divisor;
         cnt       <= 5'd31;
      end else if (step) begin
         if (!diff[32]) begin
            remainder <= diff[31:0];
            quotient  <= {quotient[30:0], 1'b1};
         end else begin
            remainder <= shifted[31:0];
            quotient  <= {quotient[30:0], 1'b0};
         end
         cnt <= cnt - 5'd1;
      end
   end

   assign last = (cnt == 5'd0);

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// EXE-stage multiply/divide controller owning the HI/LO register pair.
// Latency: MULT(U) 1+MUL_LATENCY cycles, DIV(U) 34 (2 on zero divisor), MTHI/MTLO 0.
// Backpressure: MDU_Stall freezes IF/ID/EXE while busy; a flush aborts with no HI/LO write.
module mdu_hilo_ctrl
   import mdu_hilo_ctrl_pkg::*;
#(
   parameter int          MUL_LATENCY   = 2,
   parameter bit          DIV_ZERO_FAST = 1'b1,
   parameter logic [31:0] HILO_RST_VAL  = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  EXE_MDUOp,
   input  logic        EXE_Valid,
   input  logic [31:0] EXE_BusA,
   input  logic [31:0] EXE_BusB,
   input  logic        EXE_Advance,
   input  logic        MDU_Flush,
   output logic        MDU_Stall,
   output logic        MDU_Busy,
   output logic        MDU_Done,
   output logic [31:0] HI_Out,
   output logic [31:0] LO_Out
);

   localparam logic [1:0] MUL_CNT_INIT = 2'(MUL_LATENCY - 1);

   mdu_op_t     op;
   mdu_state_t  state, state_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic        done_hold, done_hold_nxt;
   logic        is_mul, is_div, idle_ok, start, b_zero;
   logic        hi_we, lo_we;
   logic [31:0] hi_nxt, lo_nxt;
   logic [31:0] op_a, op_b;
   logic        mul_signed, zero_div, neg_q, neg_r;
   logic [63:0] mul_a_ext, mul_b_ext, mul_prod;
   logic [31:0] fix_q, fix_r;
   logic [31:0] div_a, div_b, div_q, div_r;
   logic        div_load, div_last;

   assign op     = mdu_op_t'(EXE_MDUOp);
   assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign b_zero = (EXE_BusB == 32'd0);
   assign div_a  = abs32(EXE_BusA, op == OP_DIV);
   assign div_b  = abs32(EXE_BusB, op == OP_DIV);

   // Extending to 64 bits makes one multiplier serve both signed and unsigned forms.
   assign mul_a_ext = mul_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
   assign mul_b_ext = mul_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
   assign mul_prod  = mul_a_ext * mul_b_ext;

   always_comb begin
      fix_q = neg_q ? (~div_q + 32'd1) : div_q;
      fix_r = neg_r ? (~div_r + 32'd1) : div_r;
      if (zero_div) begin
         fix_q = 32'hFFFF_FFFF;
         fix_r = op_a;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      done_hold_nxt = done_hold;
      hi_we         = 1'b0;
      lo_we         = 1'b0;
      hi_nxt        = '0;
      lo_nxt        = '0;
      div_load      = 1'b0;
      idle_ok       = EXE_Valid && !MDU_Flush && !done_hold && !rst && (state == S_IDLE);
      start         = idle_ok && (is_mul || is_div);

      case (state)
         S_IDLE: begin
            if (start && is_mul) begin
               state_nxt = S_MUL;
               cnt_nxt   = MUL_CNT_INIT;
            end else if (start) begin
               div_load  = 1'b1;
               state_nxt = (b_zero && DIV_ZERO_FAST) ? S_FIX : S_DIV;
            end else if (idle_ok && op == OP_MTHI) begin
               hi_we  = 1'b1;
               hi_nxt = EXE_BusA;
            end else if (idle_ok && op == OP_MTLO) begin
               lo_we  = 1'b1;
               lo_nxt = EXE_BusA;
            end
         end
         S_MUL: begin
            cnt_nxt = cnt - 2'd1;
            if (cnt == 2'd0) begin
               state_nxt        = S_IDLE;
               {hi_nxt, lo_nxt} = mul_prod;
               hi_we            = 1'b1;
               lo_we            = 1'b1;
            end
         end
         S_DIV: begin
            if (div_last) state_nxt = S_FIX;
         end
         S_FIX: begin
            state_nxt = S_IDLE;
            hi_nxt    = fix_r;
            lo_nxt    = fix_q;
            hi_we     = 1'b1;
            lo_we     = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (MDU_Flush) begin
         state_nxt = S_IDLE;
         hi_we     = 1'b0;
         lo_we     = 1'b0;
      end

      MDU_Done = hi_we || lo_we;
      // Advancing retires the instruction, so it wins over a same-cycle write.
      if (MDU_Flush || EXE_Advance) done_hold_nxt = 1'b0;
      else if (MDU_Done)            done_hold_nxt = 1'b1;

      MDU_Stall = start || ((state != S_IDLE) && !MDU_Flush);
      MDU_Busy  = (state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         done_hold <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         done_hold <= done_hold_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a       <= '0;
         op_b       <= '0;
         mul_signed <= 1'b0;
         zero_div   <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         HI_Out     <= HILO_RST_VAL;
         LO_Out     <= HILO_RST_VAL;
      end else begin
         if (start) begin
            op_a       <= EXE_BusA;
            op_b       <= EXE_BusB;
            mul_signed <= (op == OP_MULT);
            zero_div   <= b_zero && DIV_ZERO_FAST;
            neg_q      <= (op == OP_DIV) && (EXE_BusA[31] ^ EXE_BusB[31]);
            neg_r      <= (op == OP_DIV) && EXE_BusA[31];
         end
         if (hi_we) HI_Out <= hi_nxt;
         if (lo_we) LO_Out <= lo_nxt;
      end
   end

   div_iter_core u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (state == S_DIV),
      .dividend  (div_a),
      .divisor   (div_b),
      .quotient  (div_q),
      .remainder (div_r),
      .last      (div_last)
   );

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Self-checking bench for mdu_hilo_ctrl: directed cases plus random traffic
// compared every cycle against a cycles-remaining / plain-arithmetic model.
module tb_mdu_hilo_ctrl;
   import mdu_hilo_ctrl_pkg::*;

   localparam int          MUL_LAT = 2;
   localparam logic [31:0] RST_VAL = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  EXE_MDUOp = 3'd0;
   logic        EXE_Valid = 1'b0;
   logic [31:0] EXE_BusA = '0;
   logic [31:0] EXE_BusB = '0;
   logic        EXE_Advance = 1'b0;
   logic        MDU_Flush = 1'b0;
   logic        MDU_Stall, MDU_Busy, MDU_Done;
   logic [31:0] HI_Out, LO_Out;

   mdu_hilo_ctrl #(
      .MUL_LATENCY   (MUL_LAT),
      .DIV_ZERO_FAST (1'b1),
      .HILO_RST_VAL  (RST_VAL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .EXE_MDUOp   (EXE_MDUOp),
      .EXE_Valid   (EXE_Valid),
      .EXE_BusA    (EXE_BusA),
      .EXE_BusB    (EXE_BusB),
      .EXE_Advance (EXE_Advance),
      .MDU_Flush   (MDU_Flush),
      .MDU_Stall   (MDU_Stall),
      .MDU_Busy    (MDU_Busy),
      .MDU_Done    (MDU_Done),
      .HI_Out      (HI_Out),
      .LO_Out      (LO_Out)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Architectural result {HI, LO} of a mul/div instruction.
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, m;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      case (o)
         OP_MULT:  r = sa * sb;
         OP_MULTU: r = {32'd0, a} * {32'd0, b};
         OP_DIV: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               m = sa % sb;
               r = {m[31:0], q[31:0]};
            end
         end
         OP_DIVU: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Model: cycles left in the running op, pending result, HI/LO and the hold flag.
   int          m_rem  = 0;
   logic [63:0] m_pend = '0;
   logic [31:0] m_hi   = RST_VAL;
   logic [31:0] m_lo   = RST_VAL;
   bit          m_hold = 1'b0;
   bit          e_md, e_mt, e_start, e_done, e_stall;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_stall", {63'd0, MDU_Stall}, 64'd0);
         chk("rst_busy",  {63'd0, MDU_Busy},  64'd0);
         chk("rst_done",  {63'd0, MDU_Done},  64'd0);
         chk("rst_hi", {32'd0, HI_Out}, {32'd0, RST_VAL});
         chk("rst_lo", {32'd0, LO_Out}, {32'd0, RST_VAL});
         m_rem = 0; m_hi = RST_VAL; m_lo = RST_VAL; m_hold = 1'b0;
      end else begin
         e_md    = (EXE_MDUOp >= 3'd1) && (EXE_MDUOp <= 3'd4);
         e_mt    = (EXE_MDUOp == 3'd5) || (EXE_MDUOp == 3'd6);
         e_start = EXE_Valid && !MDU_Flush && m_rem == 0 && !m_hold && e_md;
         e_mt    = EXE_Valid && !MDU_Flush && m_rem == 0 && !m_hold && e_mt;
         e_done  = !MDU_Flush && (m_rem == 1 || e_mt);
         e_stall = e_start || (m_rem != 0 && !MDU_Flush);
         chk("stall", {63'd0, MDU_Stall}, {63'd0, e_stall});
         chk("busy",  {63'd0, MDU_Busy},  {63'd0, m_rem != 0});
         chk("done",  {63'd0, MDU_Done},  {63'd0, e_done});
         chk("hi", {32'd0, HI_Out}, {32'd0, m_hi});
         chk("lo", {32'd0, LO_Out}, {32'd0, m_lo});
         if (MDU_Flush) m_rem = 0;
         else if (m_rem != 0) begin
            m_rem--;
            if (m_rem == 0) {m_hi, m_lo} = m_pend;
         end else if (e_start) begin
            m_pend = ref_result(EXE_MDUOp, EXE_BusA, EXE_BusB);
            if (EXE_MDUOp == OP_MULT || EXE_MDUOp == OP_MULTU) m_rem = MUL_LAT;
            else m_rem = (EXE_BusB == 0) ? 1 : 33;
         end else if (e_mt) begin
            if (EXE_MDUOp == OP_MTHI) m_hi = EXE_BusA;
            else m_lo = EXE_BusA;
         end
         m_hold = (MDU_Flush || EXE_Advance) ? 1'b0 : (e_done ? 1'b1 : m_hold);
      end
   end

   // Issue one instruction (entered just after a rising edge), hold it in EXE until
   // the stall drops plus adv_delay cycles, advance it, then retire it.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int adv_delay, output int stalls, output int dones);
      int  idle_cnt;
      bit  timeout;
      stalls = 0; dones = 0; idle_cnt = 0; timeout = 1'b1;
      EXE_Valid = 1'b1; EXE_MDUOp = o; EXE_BusA = a; EXE_BusB = b;
      EXE_Advance = 1'b0; MDU_Flush = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (MDU_Stall) stalls++; else idle_cnt++;
         if (MDU_Done) dones++;
         @(posedge clk); #1;
         if (idle_cnt == adv_delay + 1) EXE_Advance = 1'b1;
         else if (idle_cnt == adv_delay + 2) begin
            timeout = 1'b0;
            break;
         end
      end
      EXE_Advance = 1'b0; EXE_Valid = 1'b0; EXE_MDUOp = OP_NONE;
      if (timeout) begin
         n_chk++;
         $display("FAIL run_op_timeout: op %0d still stalled after 200 cycles", o);
      end
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int stalls, dones;

      chk("model_div_neg7_2",  ref_result(OP_DIV, 32'hFFFF_FFF9, 32'd2),  64'hFFFF_FFFF_FFFF_FFFD);
      chk("model_mult_neg3_7", ref_result(OP_MULT, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);

      @(posedge clk); #1;
      chk("reset_stall", {63'd0, MDU_Stall}, 64'd0);
      chk("reset_hi", {32'd0, HI_Out}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, stalls, dones);
      chk("multu_stalls", stalls, 3);
      chk("multu_dones", dones, 1);
      chk("multu_hi", {32'd0, HI_Out}, 64'h1);
      chk("multu_lo", {32'd0, LO_Out}, 64'hFFFF_FFFE);

      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, stalls, dones);
      chk("div_stalls", stalls, 34);
      chk("div_lo", {32'd0, LO_Out}, 64'hFFFF_FFFD);
      chk("div_hi", {32'd0, HI_Out}, 64'hFFFF_FFFF);

      run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 0, stalls, dones);
      chk("divu_lo", {32'd0, LO_Out}, 64'h7FFF_FFFC);
      chk("divu_hi", {32'd0, HI_Out}, 64'h1);

      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, stalls, dones);
      chk("div_ovf_lo", {32'd0, LO_Out}, 64'h8000_0000);
      chk("div_ovf_hi", {32'd0, HI_Out}, 64'h0);

      run_op(OP_DIVU, 32'd5, 32'd0, 0, stalls, dones);
      chk("divz_stalls", stalls, 2);
      chk("divz_lo", {32'd0, LO_Out}, 64'hFFFF_FFFF);
      chk("divz_hi", {32'd0, HI_Out}, 64'h5);

      // Flush part-way through a divide.
      EXE_Valid = 1'b1; EXE_MDUOp = OP_DIV; EXE_BusA = 32'hFFFF_FFF9; EXE_BusB = 32'd2;
      repeat (10) @(posedge clk);
      #1 MDU_Flush = 1'b1;
      #1;
      chk("flush_stall", {63'd0, MDU_Stall}, 64'd0);
      chk("flush_done",  {63'd0, MDU_Done},  64'd0);
      chk("flush_busy",  {63'd0, MDU_Busy},  64'd1);
      @(posedge clk); #1;
      MDU_Flush = 1'b0; EXE_Valid = 1'b0; EXE_MDUOp = OP_NONE;
      #1;
      chk("flush_idle", {63'd0, MDU_Busy}, 64'd0);
      chk("flush_hi", {32'd0, HI_Out}, 64'h5);
      chk("flush_lo", {32'd0, LO_Out}, 64'hFFFF_FFFF);
      @(posedge clk); #1;

      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 3, stalls, dones);
      chk("mult_held_stalls", stalls, 3);
      chk("mult_held_dones", dones, 1);
      chk("mult_hi", {32'd0, HI_Out}, 64'hFFFF_FFFF);
      chk("mult_lo", {32'd0, LO_Out}, 64'hFFFF_FFEB);

      run_op(OP_MTLO, 32'h1234, 32'd0, 0, stalls, dones);
      chk("mtlo_stalls", stalls, 0);
      chk("mtlo_dones", dones, 1);
      chk("mtlo_lo", {32'd0, LO_Out}, 64'h1234);

      run_op(OP_MTHI, 32'hCAFE_F00D, 32'd0, 0, stalls, dones);
      chk("mthi_hi", {32'd0, HI_Out}, 64'hCAFE_F00D);

      // Asynchronous reset in the middle of a divide.
      EXE_Valid = 1'b1; EXE_MDUOp = OP_DIV; EXE_BusA = 32'd100; EXE_BusB = 32'd7;
      repeat (6) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_stall", {63'd0, MDU_Stall}, 64'd0);
      chk("arst_busy",  {63'd0, MDU_Busy},  64'd0);
      chk("arst_done",  {63'd0, MDU_Done},  64'd0);
      chk("arst_hi", {32'd0, HI_Out}, {32'd0, RST_VAL});
      chk("arst_lo", {32'd0, LO_Out}, {32'd0, RST_VAL});
      @(posedge clk); #1;
      rst = 1'b0; EXE_Valid = 1'b0; EXE_MDUOp = OP_NONE;

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            EXE_MDUOp = 3'($urandom_range(0, 6));
            EXE_BusA  = rnd_operand();
            EXE_BusB  = rnd_operand();
         end
         EXE_Valid   = ($urandom_range(0, 7) != 0);
         EXE_Advance = ($urandom_range(0, 2) == 0);
         MDU_Flush   = ($urandom_range(0, 79) == 0);
         @(posedge clk); #1;
      end
      EXE_Valid = 1'b0; EXE_Advance = 1'b0; MDU_Flush = 1'b0; EXE_MDUOp = OP_NONE;
      repeat (2) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
